nibble_pair_packer: RTL and testbench
=====================================

// Module: nibble_pair_packer
// PURPOSE
//   Upstream producer for packed-struct consumers. Accepts a valid/ready stream of
//   4-bit nibbles and assembles four of them into one 16-bit pair_of_pairs_t:
//   {first:{upper,lower}, second:{upper,lower}}. The assembled word is presented
//   on a registered valid/ready output. Sustains one nibble per clock while the
//   output is not stalled.
// PARAMETERS
//   PAD_NIBBLE  4'h0  fill value for nibble slots not written before in_last
//   MSB_FIRST   1     1: 1st nibble -> first.upper ([15:12]); 0: 1st nibble -> second.lower ([3:0])
//   CNT_W       16    width of the out_word_count counter
// PORTS
//   clk             in   1      single clock, rising edge
//   rst             in   1      synchronous reset, active-high
//   in_valid        in   1      in_nibble/in_last are valid
//   in_ready        out  1      packer accepts the beat this cycle
//   in_nibble       in   4      data nibble
//   in_last         in   1      final nibble of a packet; forces word emission
//   out_valid       out  1      out_word is valid
//   out_ready       in   1      downstream accepts out_word
//   out_word        out  16     pair_of_pairs_t: [15:12] first.upper, [11:8] first.lower,
//                                [7:4] second.upper, [3:0] second.lower
//   out_nibbles     out  3      real nibbles in out_word (1..4); 0 when idle
//   out_last        out  1      out_word closes a packet
//   out_word_count  out  CNT_W  words emitted since reset, wrapping
// BEHAVIOUR
//   - Reset (rst=1 at posedge): fill cnt=0, accumulator=all PAD_NIBBLE, out_valid=0,
//     out_word=16'h0, out_nibbles=0, out_last=0, out_word_count=0. Reset overrides all
//     other events in that cycle. Any partial word or unsent output is discarded.
//   - Accept: beat = in_valid & in_ready. Nibble goes to slot cnt, counted in fill
//     order. Fill order is [15:12],[11:8],[7:4],[3:0] if MSB_FIRST=1, reversed if 0.
//   - Completing beat: a beat with cnt==3 or in_last=1.
//   - in_ready = !completing || !out_valid || out_ready. Non-completing beats are
//     always accepted. in_ready is combinational on out_ready and cnt.
//   - On a completing beat, the word loads into the output register at the same edge:
//     - accumulator merged with the incoming nibble;
//     - unfilled slots set to PAD_NIBBLE;
//     - out_nibbles=cnt+1, out_last=in_last, out_valid=1.
//     The accumulator then resets to PAD and cnt to 0. Latency is 1 clock from the
//     final beat to out_valid.
//   - Output handshake: the word transfers when out_valid & out_ready. out_word,
//     out_nibbles and out_last hold stable while out_valid=1 and out_ready=0.
//     out_valid clears after the transfer unless a completing beat reloads it at the
//     same edge. Back-to-back words are allowed, with no bubble.
//   - out_word_count increments by 1 on each output transfer and wraps to 0 after
//     2^CNT_W-1.
//   - State machine:
//     - EMPTY (cnt=0) -> FILL on a non-completing beat.
//     - FILL (cnt 1..3) -> EMPTY on a completing beat.
//     - A single-nibble in_last beat in EMPTY emits immediately with out_nibbles=1.
//     - The output register is an independent 1-entry stage with states IDLE and HOLD.
//   - Simultaneous output transfer and completing beat: the new word replaces the old
//     one. out_valid stays 1 and no beat is lost or duplicated.
//   - Stall: with out_valid=1 and out_ready=0, up to 3 nibbles can still be accepted
//     into the accumulator. The completing nibble waits with in_ready=0.
//   - in_last with cnt==3 is a normal full word with out_last=1.
//   - in_valid=0 never changes cnt. Upstream must not retract in_valid or change data
//     while in_ready=0.
// TESTING
//   1. Reset, then beats A,B,C,D on consecutive cycles with out_ready=1 ->
//      out_valid=1 one cycle after D, out_word=16'hABCD, out_nibbles=4, out_last=0,
//      out_word_count=1 after transfer.
//   2. Beats 1,2,3 with in_last on 3 and PAD_NIBBLE=4'h0 -> out_word=16'h1230,
//      out_nibbles=3, out_last=1. Same stimulus with MSB_FIRST=0 -> out_word=16'h0321.
//   3. Hold out_ready=0 and stream 8 nibbles 0..7 -> first word 16'h0123 held stable,
//      nibbles 4,5,6 accepted, in_ready=0 on nibble 7. Release out_ready ->
//      16'h4567 follows with no loss.
//   4. Continuous 16-nibble stream with out_ready=1 -> 4 words, out_valid high on
//      every 4th cycle, in_ready never 0.
//   5. Assert rst after 2 nibbles and while a word is held -> next cycle out_valid=0,
//      counter=0. Beats E,F,0,1 then give 16'hEF01.
//   6. CNT_W=2: 5 transfers -> out_word_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/nibble_pair_packer_if.sv
// nibble_pair_packer_if: nibble input stream and packed-word output stream of the packer.
interface nibble_pair_packer_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_nibble;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_word;
   logic [2:0]       out_nibbles;
   logic             out_last;
   logic [CNT_W-1:0] out_word_count;
   modport master (
      output in_valid, in_nibble, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_nibbles, out_last, out_word_count
   );
   modport slave (
      input  in_valid, in_nibble, in_last, out_ready,
      output in_ready, out_valid, out_word, out_nibbles, out_last, out_word_count
   );
endinterface

// File: rtl/nibble_pair_packer.sv
// nibble_pair_packer: packs up to four nibbles into a 16-bit word behind a 1-entry output stage.
module nibble_pair_packer #(
   parameter logic [3:0] PAD_NIBBLE = 4'h0,
   parameter bit         MSB_FIRST  = 1'b1,
   parameter int         CNT_W      = 16
) (
   input logic                 clk,
   input logic                 rst,
   nibble_pair_packer_if.slave bus
);
   typedef enum logic {EMPTY, FILL} fill_t;
   typedef enum logic {IDLE, HOLD} hold_t;
   fill_t            fill_q, fill_d;
   hold_t            hold_q, hold_d;
   logic [1:0]       cnt_q, cnt_d, slot;
   logic [15:0]      acc_q, acc_d, word_q, word_d, merged;
   logic [2:0]       nib_q, nib_d;
   logic             last_q, last_d, completing, beat, xfer, load;
   logic [CNT_W-1:0] wc_q, wc_d;
   assign completing = bus.in_valid && (cnt_q == 2'd3 || bus.in_last);
   assign bus.in_ready = !completing || hold_q == IDLE || bus.out_ready;
   assign beat = bus.in_valid && bus.in_ready;
   assign load = beat && completing;
   assign xfer = hold_q == HOLD && bus.out_ready;
   assign slot = MSB_FIRST ? 2'd3 - cnt_q : cnt_q;
   always_comb begin
      merged = fill_q == FILL ? acc_q : {4{PAD_NIBBLE}};
      merged[{slot, 2'b00} +: 4] = bus.in_nibble;
      fill_d = beat ? (completing ? EMPTY : FILL) : fill_q;
      cnt_d  = beat ? (completing ? 2'd0 : cnt_q + 2'd1) : cnt_q;
      acc_d  = beat ? (completing ? {4{PAD_NIBBLE}} : merged) : acc_q;
      // a reload in the same cycle as a transfer keeps the stage occupied
      hold_d = load ? HOLD : (xfer ? IDLE : hold_q);
      word_d = load ? merged : word_q;
      nib_d  = load ? {1'b0, cnt_q} + 3'd1 : nib_q;
      last_d = load ? bus.in_last : last_q;
      wc_d   = wc_q + CNT_W'(xfer);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= EMPTY;
         hold_q <= IDLE;
         cnt_q  <= 2'd0;
         acc_q  <= {4{PAD_NIBBLE}};
         word_q <= 16'h0;
         nib_q  <= 3'd0;
         last_q <= 1'b0;
         wc_q   <= '0;
      end else begin
         fill_q <= fill_d;
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         word_q <= word_d;
         nib_q  <= nib_d;
         last_q <= last_d;
         wc_q   <= wc_d;
      end
   end
   assign bus.out_valid      = hold_q == HOLD;
   assign bus.out_word       = word_q;
   assign bus.out_nibbles    = hold_q == HOLD ? nib_q : 3'd0;
   assign bus.out_last       = last_q;
   assign bus.out_word_count = wc_q;
endmodule

// File: tb/tb_nibble_pair_packer.sv
// tb_nibble_pair_packer: three parameterisations driven by one stream, checked against a queue-level model.
module tb_nibble_pair_packer;
   logic clk = 1'b0, rst = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [3:0] in_nibble = 4'h0;
   always #5 clk = ~clk;

   nibble_pair_packer_if #(.CNT_W(16)) i0 ();
   nibble_pair_packer_if #(.CNT_W(2))  i1 ();
   nibble_pair_packer_if #(.CNT_W(3))  i2 ();
   nibble_pair_packer #(.PAD_NIBBLE(4'h0), .MSB_FIRST(1'b1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(i0));
   nibble_pair_packer #(.PAD_NIBBLE(4'h0), .MSB_FIRST(1'b0), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(i1));
   nibble_pair_packer #(.PAD_NIBBLE(4'hF), .MSB_FIRST(1'b1), .CNT_W(3))  u2 (.clk(clk), .rst(rst), .bus(i2));

   assign i0.in_valid = in_valid; assign i0.in_nibble = in_nibble; assign i0.in_last = in_last; assign i0.out_ready = out_ready;
   assign i1.in_valid = in_valid; assign i1.in_nibble = in_nibble; assign i1.in_last = in_last; assign i1.out_ready = out_ready;
   assign i2.in_valid = in_valid; assign i2.in_nibble = in_nibble; assign i2.in_last = in_last; assign i2.out_ready = out_ready;

   logic rdy [3], ov [3], lst [3];
   logic [15:0] wd [3], wc [3];
   logic [2:0] nb [3];
   assign rdy[0] = i0.in_ready; assign ov[0] = i0.out_valid; assign wd[0] = i0.out_word;
   assign nb[0] = i0.out_nibbles; assign lst[0] = i0.out_last; assign wc[0] = i0.out_word_count;
   assign rdy[1] = i1.in_ready; assign ov[1] = i1.out_valid; assign wd[1] = i1.out_word;
   assign nb[1] = i1.out_nibbles; assign lst[1] = i1.out_last; assign wc[1] = 16'(i1.out_word_count);
   assign rdy[2] = i2.in_ready; assign ov[2] = i2.out_valid; assign wd[2] = i2.out_word;
   assign nb[2] = i2.out_nibbles; assign lst[2] = i2.out_last; assign wc[2] = 16'(i2.out_word_count);

   int n_cmp = 0, n_err = 0;
   int m_cnt [3], m_nib [3], m_wc [3];
   logic [3:0] m_buf [3][4];
   logic m_ov [3], m_last [3];
   logic [15:0] m_word [3];
   logic a, pend;
   logic [3:0] pn;
   logic pl;

   function automatic logic [3:0] pad_of(int k); return k == 2 ? 4'hF : 4'h0; endfunction
   function automatic logic msb_of(int k); return k != 1; endfunction
   function automatic int wid_of(int k); return k == 0 ? 16 : (k == 1 ? 2 : 3); endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s dut%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   function automatic logic m_rdy(int k);
      logic comp;
      comp = in_valid && (m_cnt[k] == 3 || in_last);
      return !comp || !m_ov[k] || out_ready;
   endfunction

   task automatic m_step(input int k);
      logic bt, xf;
      logic [15:0] w;
      logic [3:0] v;
      bt = in_valid && m_rdy(k);
      xf = m_ov[k] && out_ready;
      if (xf) begin
         m_ov[k] = 1'b0;
         m_wc[k] = (m_wc[k] + 1) % (1 << wid_of(k));
      end
      if (bt) begin
         m_buf[k][m_cnt[k]] = in_nibble;
         if (m_cnt[k] == 3 || in_last) begin
            w = 16'h0;
            for (int j = 0; j < 4; j++) begin
               v = j <= m_cnt[k] ? m_buf[k][j] : pad_of(k);
               w |= 16'(v) << (msb_of(k) ? 4 * (3 - j) : 4 * j);
            end
            m_word[k] = w;
            m_ov[k] = 1'b1;
            m_nib[k] = m_cnt[k] + 1;
            m_last[k] = in_last;
            m_cnt[k] = 0;
         end else m_cnt[k]++;
      end
   endtask

   task automatic cyc(input logic v, input logic [3:0] n, input logic l, input logic r, output logic acc);
      in_valid = v; in_nibble = n; in_last = l; out_ready = r;
      #1;
      acc = v && m_rdy(0);
      for (int k = 0; k < 3; k++) chk("in_ready", k, 32'(rdy[k]), 32'(m_rdy(k)));
      for (int k = 0; k < 3; k++) m_step(k);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("out_valid", k, 32'(ov[k]), 32'(m_ov[k]));
         chk("out_nibbles", k, 32'(nb[k]), m_ov[k] ? 32'(m_nib[k]) : 32'd0);
         chk("out_word_count", k, 32'(wc[k]), 32'(m_wc[k]));
         if (m_ov[k]) begin
            chk("out_word", k, 32'(wd[k]), 32'(m_word[k]));
            chk("out_last", k, 32'(lst[k]), 32'(m_last[k]));
         end
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] n, input logic l, input logic r);
      logic acc;
      int t;
      t = 0;
      do begin
         cyc(1'b1, n, l, r, acc);
         t++;
      end while (!acc && t < 20);
      if (!acc) begin
         n_cmp++; n_err++;
         $error("FAIL send_timeout dut0 got=not_accepted exp=accepted");
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'($urandom); in_nibble = 4'($urandom); in_last = 1'($urandom); out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0; m_ov[k] = 1'b0; m_wc[k] = 0; m_nib[k] = 0; m_last[k] = 1'b0; m_word[k] = 16'h0;
         chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
         chk("rst_out_word", k, 32'(wd[k]), 32'd0);
         chk("rst_out_nibbles", k, 32'(nb[k]), 32'd0);
         chk("rst_out_last", k, 32'(lst[k]), 32'd0);
         chk("rst_count", k, 32'(wc[k]), 32'd0);
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      // full word, streaming
      send(4'hA, 0, 1); send(4'hB, 0, 1); send(4'hC, 0, 1); send(4'hD, 0, 1);
      chk("t1_word", 0, 32'(wd[0]), 32'h0000ABCD);
      chk("t1_nibbles", 0, 32'(nb[0]), 32'd4);
      cyc(0, 4'h0, 0, 1, a);
      chk("t1_count", 0, 32'(wc[0]), 32'd1);
      // short packet padded
      send(4'h1, 0, 1); send(4'h2, 0, 1); send(4'h3, 1, 1);
      chk("t2_word_msb", 0, 32'(wd[0]), 32'h00001230);
      chk("t2_word_lsb", 1, 32'(wd[1]), 32'h00000321);
      chk("t2_word_padf", 2, 32'(wd[2]), 32'h0000123F);
      chk("t2_last", 0, 32'(lst[0]), 32'd1);
      chk("t2_nibbles", 0, 32'(nb[0]), 32'd3);
      cyc(0, 4'h0, 0, 1, a);
      // stall: word held, three more nibbles taken, the completing one waits
      for (int i = 0; i < 7; i++) send(4'(i), 0, 0);
      for (int i = 0; i < 2; i++) begin
         cyc(1, 4'h7, 0, 0, a);
         chk("t3_stall_ready", 0, 32'(rdy[0]), 32'd0);
         chk("t3_hold_word", 0, 32'(wd[0]), 32'h00000123);
      end
      send(4'h7, 0, 1);
      chk("t3_next_word", 0, 32'(wd[0]), 32'h00004567);
      cyc(0, 4'h0, 0, 1, a);
      // continuous stream
      for (int i = 0; i < 16; i++) send(4'(i), 0, 1);
      cyc(0, 4'h0, 0, 1, a);
      // reset with a held word and a partial word
      for (int i = 0; i < 6; i++) send(4'(9 - i), 0, 0);
      do_reset();
      send(4'hE, 0, 1); send(4'hF, 0, 1); send(4'h0, 0, 1); send(4'h1, 0, 1);
      chk("t5_word", 0, 32'(wd[0]), 32'h0000EF01);
      cyc(0, 4'h0, 0, 1, a);
      // narrow counter wrap
      do_reset();
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 4; j++) send(4'(j), 0, 1);
         cyc(0, 4'h0, 0, 1, a);
         chk("t6_wrap", 1, 32'(wc[1]), 32'((i + 1) % 4));
      end
      // random traffic with random backpressure
      pend = 1'b0; pn = 4'h0; pl = 1'b0;
      repeat (800) begin
         if (!pend && $urandom_range(3) != 0) begin
            pend = 1'b1; pn = 4'($urandom); pl = ($urandom_range(4) == 0);
         end
         cyc(pend, pend ? pn : 4'($urandom), pend ? pl : 1'($urandom), $urandom_range(2) != 0, a);
         if (a) pend = 1'b0;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
